led_p2s_tx: RTL
===============

// Module: led_p2s_tx
// PURPOSE
//  Parallel-to-serial transmitter: consumes the 16-bit display word produced by the
//  number-entry logic and shifts it out to the board's external serial LED shift
//  registers (74HC164-style chain plus output latch). Sits between the number
//  source and the LED/segment pins; one frame per start request.
// PARAMETERS
//  DATA_WIDTH  16  bits per frame, shifted MSB first
//  CLK_DIV     2   clk cycles per sclk half-period (>=1)
// PORTS
//  clk      in   1           system clock, all logic on rising edge
//  rst_n    in   1           asynchronous reset, active low
//  start    in   1           frame request, sampled only in IDLE
//  data     in   DATA_WIDTH  word to send, captured on the accepting edge
//  sclk     out  1           serial clock to shift-register chain
//  sdata    out  1           serial data, stable across each sclk rising edge
//  sclr_n   out  1           shift-register clear, active low
//  sen      out  1           output-latch enable pulse after last bit
//  busy     out  1           frame in progress
//  done     out  1           one-cycle frame-complete strobe
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; sclk=0, sdata=0, sen=0, busy=0, done=0,
//    sclr_n=0, counters and shift register=0. sclr_n goes 1 on first clk edge after
//    rst_n deasserts. Reset mid-frame aborts immediately; no partial latch pulse.
//  - FSM: IDLE -> SHIFT -> LATCH -> DONE -> IDLE.
//  - IDLE: start=1 at an edge -> load shreg<=data, bitcnt=0, divcnt=0, sclk=0,
//    sdata=data[DATA_WIDTH-1], busy<=1, go SHIFT. start=0: hold, outputs idle.
//  - SHIFT: divcnt counts 0..CLK_DIV-1; at CLK_DIV-1 toggle sclk, divcnt<=0.
//    Low->high toggle: receiver samples sdata. High->low toggle: shreg<<=1,
//    sdata<=next bit, bitcnt++; if bitcnt was DATA_WIDTH-1 go LATCH instead.
//    SHIFT lasts exactly 2*CLK_DIV*DATA_WIDTH cycles, DATA_WIDTH rising sclk edges.
//  - LATCH: sclk=0, sdata=0, sen=1 for CLK_DIV cycles, then go DONE.
//  - DONE: sen=0, busy=0, done=1 for exactly one cycle, then IDLE.
//  - Latency: start edge to done high = 2*CLK_DIV*DATA_WIDTH + CLK_DIV + 1 cycles.
//  - start while busy or in DONE is ignored (not queued). data changes after the
//    accepting edge do not affect the frame in flight.
//  - start held high continuously: back-to-back frames, one IDLE cycle between.
//  - Counter widths: divcnt $clog2(CLK_DIV)+1, bitcnt $clog2(DATA_WIDTH)+1; no wrap
//    within a frame.
// CONFIGURATION
//  LED_P2S_INVERT_EN defined: sdata carries ~shreg bit (active-low LEDs); idle and
//    reset level of sdata becomes 1. Undefined: sdata carries true data, idle 0.
//    FSM timing identical either way.
// TESTING (DATA_WIDTH=16, CLK_DIV=2, macro undefined unless stated)
//  1 start=1 one cycle, data=16'hABCD -> bits at sclk rises 1010_1011_1100_1101,
//    sen high 2 cycles, done at cycle 67 after accept, busy high cycles 1..66.
//  2 data=16'h0000 then 16'hFFFF frames -> sdata constant 0 / 1 across 16 rises.
//  3 start pulsed again at cycle 20 of a frame, data=16'h1234 -> ignored; frame
//    completes with original word, no second frame.
//  4 rst_n low at cycle 30 of a frame -> sclk/sdata/sen/busy/done 0, sclr_n 0 at
//    once; after release, sclr_n=1 next edge, new frame 16'h5A5A sends cleanly.
//  5 start held high -> consecutive frames, exactly one IDLE cycle between done
//    and next busy.
//  6 LED_P2S_INVERT_EN defined, data=16'hABCD -> rises see 0101_0100_0011_0010,
//    sdata=1 in idle and reset.

Source files
------------

// File: rtl/led_p2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_p2s_tx : parallel-to-serial driver for an external 74HC164-style LED    |
// |              chain with output latch; one MSB-first frame per start.        |
// | Option macro: LED_P2S_INVERT_EN (active-low LEDs, idle sdata level 1).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_p2s_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  sclk,
   output logic                  sdata,
   output logic                  sclr_n,
   output logic                  sen,
   output logic                  busy,
   output logic                  done
);

   localparam int c_div_w = $clog2(CLK_DIV) + 1;
   localparam int c_bit_w = $clog2(DATA_WIDTH) + 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);

`ifdef LED_P2S_INVERT_EN
   localparam logic c_idle_level = 1'b1;
`else
   localparam logic c_idle_level = 1'b0;
`endif

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_shift = 2'd1;
   localparam logic [1:0] c_st_latch = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [c_bit_w-1:0]    r_bitcnt;
   logic [c_div_w-1:0]    r_divcnt;
   logic                  r_sclk;
   logic                  r_sclr_n;
   logic                  w_div_wrap;
   logic                  w_sclk_fall;

   assign w_div_wrap  = (r_divcnt == c_div_last);
   assign w_sclk_fall = w_div_wrap & r_sclk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:  if (start) w_next_state = c_st_shift;
         c_st_shift: if (w_sclk_fall && (r_bitcnt == c_bit_last)) w_next_state = c_st_latch;
         c_st_latch: if (w_div_wrap) w_next_state = c_st_done;
         c_st_done:  w_next_state = c_st_idle;
         default:    w_next_state = c_st_idle;
      endcase
   end

   // Datapath: divider, bit counter, shift register and serial clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_divcnt <= '0;
         r_sclk   <= 1'b0;
         r_sclr_n <= 1'b0;
      end else begin
         r_sclr_n <= 1'b1;
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_shreg  <= data;
                  r_bitcnt <= '0;
                  r_divcnt <= '0;
                  r_sclk   <= 1'b0;
               end
            end
            c_st_shift: begin
               if (w_div_wrap) begin
                  r_divcnt <= '0;
                  r_sclk   <= ~r_sclk;
                  if (r_sclk) begin
                     r_shreg  <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end else begin
                  r_divcnt <= r_divcnt + 1'b1;
               end
            end
            c_st_latch: begin
               r_sclk   <= 1'b0;
               r_divcnt <= w_div_wrap ? '0 : r_divcnt + 1'b1;
            end
            default: begin
               r_sclk <= 1'b0;
            end
         endcase
      end
   end

   // sdata follows the shift-register MSB only while shifting; it sits at the
   // idle level everywhere else, including the latch pulse and reset.
   always_comb begin
      sclk   = r_sclk;
      sclr_n = r_sclr_n;
      sdata  = c_idle_level;
      sen    = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         c_st_shift: begin
            busy  = 1'b1;
            sdata = r_shreg[DATA_WIDTH-1] ^ c_idle_level;
         end
         c_st_latch: begin
            busy = 1'b1;
            sen  = 1'b1;
         end
         c_st_done: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
